perf_sample_ctrl: RTL and testbench

- Autonomous sampler and arbiter for the NPU performance-counter register port.
- Periodically, or on demand, snapshots the perf counters coherently: reads CTRL, sets FREEZE, reads all count words, restores CTRL.
- Pushes the captured words into a sample FIFO that host/DMA drains.
- Shares the counter register port with host accesses; host is granted only while the sampler is idle.

---
 rtl/perf_sample_ctrl.sv | 177 +++++++++++++++++
 tb/tb_perf_sample_ctrl.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/perf_sample_ctrl.sv
// perf_sample_ctrl: periodic / on-demand coherent snapshot of the perf-counter register port into
// a sample FIFO, arbitrating the port against host accesses. Option macro: PERF_SAMPLE_TAG_EN.
module perf_sample_ctrl #(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned ADDR_WIDTH    = 8,
  parameter int unsigned NUM_EVT_WORDS = 16,
  parameter int unsigned FIFO_DEPTH    = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic [31:0]           period,
  input  logic                  sample_now,
  input  logic                  host_req,
  input  logic                  host_wr,
  input  logic [ADDR_WIDTH-1:0] host_addr,
  input  logic [DATA_WIDTH-1:0] host_wdata,
  output logic [DATA_WIDTH-1:0] host_rdata,
  output logic                  host_ready,
  output logic                  pc_reg_wr,
  output logic [ADDR_WIDTH-1:0] pc_reg_addr,
  output logic [DATA_WIDTH-1:0] pc_reg_wdata,
  input  logic [DATA_WIDTH-1:0] pc_reg_rdata,
  output logic                  smp_valid,
  output logic [DATA_WIDTH-1:0] smp_data,
  input  logic                  smp_ready,
  output logic                  busy,
  output logic [15:0]           sample_cnt,
  output logic [15:0]           drop_cnt
);

  localparam int unsigned W  = 2 + NUM_EVT_WORDS;
`ifdef PERF_SAMPLE_TAG_EN
  localparam int unsigned SMP_WORDS = W + 1;
`else
  localparam int unsigned SMP_WORDS = W;
`endif
  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned IW = $clog2(W);

  typedef enum logic [2:0] {StIdle, StRdCtrl, StFreeze, StRead, StRestore} state_e;

  state_e                state_q, state_d, state;
  logic [31:0]           tmr_q, tmr_d;
  logic                  pending_q, pending_d, enable_q;
  logic [7:0]            saved_ctrl_q, saved_ctrl_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [PW:0]           wptr_q, rptr_q, level;
  logic [15:0]           sample_cnt_q, drop_cnt_q, drop_cnt_d;
  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic                  tmr_hit, trig, want, has_space, start, reject;
  logic                  push, pop, sample_inc;
  logic [DATA_WIDTH-1:0] push_data;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [16:0]           drop_sum;

  assign tmr_hit = enable && (period != 32'd0) && (tmr_q == period - 32'd1);
  assign trig    = tmr_hit | sample_now;

  always_comb begin
    tmr_d = tmr_q;
    if (!enable)                tmr_d = '0;
    else if (period != 32'd0)   tmr_d = tmr_hit ? '0 : tmr_q + 32'd1;
  end

  assign level     = wptr_q - rptr_q;
  assign has_space = 32'(level) <= FIFO_DEPTH - SMP_WORDS;
  assign want      = (state_q == StIdle) && (pending_q || trig);
  assign start     = want && has_space;
  assign reject    = want && !has_space;
  // The start cycle already performs the CTRL read, so the sequence is 3 + W cycles in total.
  assign state     = start ? StRdCtrl : state_q;
  assign busy      = (state != StIdle);

  always_comb begin
    rd_addr = ADDR_WIDTH'(32'h18 + (32'(idx_q) << 2));
    if (idx_q == '0)         rd_addr = ADDR_WIDTH'(32'h10);
    else if (idx_q == IW'(1)) rd_addr = ADDR_WIDTH'(32'h14);
  end

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    saved_ctrl_d = saved_ctrl_q;
    pc_reg_wr    = 1'b0;
    pc_reg_addr  = '0;
    pc_reg_wdata = '0;
    host_ready   = 1'b0;
    push         = 1'b0;
    push_data    = pc_reg_rdata;
    sample_inc   = 1'b0;
    unique case (state)
      StIdle: begin
        pc_reg_wr    = host_req & host_wr;
        pc_reg_addr  = host_addr;
        pc_reg_wdata = host_wdata;
        host_ready   = host_req;
      end
      StRdCtrl: begin
        saved_ctrl_d = pc_reg_rdata[7:0] & 8'hFD;
        state_d      = StFreeze;
      end
      StFreeze: begin
        pc_reg_wr    = 1'b1;
        pc_reg_wdata = DATA_WIDTH'(saved_ctrl_q | 8'h04);
        idx_d        = '0;
        state_d      = StRead;
`ifdef PERF_SAMPLE_TAG_EN
        push         = 1'b1;
        push_data    = DATA_WIDTH'({sample_cnt_q, 8'(W), 8'hA5});
`endif
      end
      StRead: begin
        pc_reg_addr = rd_addr;
        push        = 1'b1;
        if (idx_q == IW'(W - 1)) state_d = StRestore;
        else                     idx_d   = idx_q + IW'(1);
      end
      StRestore: begin
        pc_reg_wr    = 1'b1;
        pc_reg_wdata = DATA_WIDTH'(saved_ctrl_q);
        sample_inc   = 1'b1;
        state_d      = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // A trigger colliding with an already-pending one and a space rejection can land together.
  assign drop_sum = {1'b0, drop_cnt_q} + 17'(trig & pending_q) + 17'(reject);

  always_comb begin
    drop_cnt_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    if (enable && !enable_q) drop_cnt_d = '0;
    pending_d = pending_q;
    if (want)      pending_d = 1'b0;
    else if (trig) pending_d = 1'b1;
  end

  assign pop        = smp_valid & smp_ready;
  assign smp_valid  = (wptr_q != rptr_q);
  assign smp_data   = smp_valid ? mem[rptr_q[PW-1:0]] : '0;
  assign host_rdata = pc_reg_rdata;
  assign sample_cnt = sample_cnt_q;
  assign drop_cnt   = drop_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      tmr_q        <= '0;
      pending_q    <= 1'b0;
      enable_q     <= 1'b0;
      saved_ctrl_q <= '0;
      idx_q        <= '0;
      wptr_q       <= '0;
      rptr_q       <= '0;
      sample_cnt_q <= '0;
      drop_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      tmr_q        <= tmr_d;
      pending_q    <= pending_d;
      enable_q     <= enable;
      saved_ctrl_q <= saved_ctrl_d;
      idx_q        <= idx_d;
      drop_cnt_q   <= drop_cnt_d;
      if (push)       wptr_q       <= wptr_q + 1'b1;
      if (pop)        rptr_q       <= rptr_q + 1'b1;
      if (sample_inc) sample_cnt_q <= sample_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wptr_q[PW-1:0]] <= push_data;
  end

endmodule

// File: tb/tb_perf_sample_ctrl.sv
// tb_perf_sample_ctrl: directed bench with a sequence-position reference model, a simple
// counter-block model, and hand-computed expectations for the key scenarios.
module tb_perf_sample_ctrl;
  localparam int unsigned DW = 32, AW = 8, NE = 16, DEPTH = 32;
  localparam int W = 2 + NE;
`ifdef PERF_SAMPLE_TAG_EN
  localparam int SW = W + 1;
  localparam int HDR = 1;
`else
  localparam int SW = W;
  localparam int HDR = 0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic enable = 1'b0, sample_now = 1'b0, host_req = 1'b0, host_wr = 1'b0, smp_ready = 1'b0;
  logic [31:0] period = 32'd0;
  logic [AW-1:0] host_addr = '0;
  logic [DW-1:0] host_wdata = '0;
  logic [DW-1:0] host_rdata, pc_reg_wdata, pc_reg_rdata, smp_data;
  logic [AW-1:0] pc_reg_addr;
  logic host_ready, pc_reg_wr, smp_valid, busy;
  logic [15:0] sample_cnt, drop_cnt;

  perf_sample_ctrl #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_EVT_WORDS(NE), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .period(period), .sample_now(sample_now),
    .host_req(host_req), .host_wr(host_wr), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_rdata(host_rdata), .host_ready(host_ready), .pc_reg_wr(pc_reg_wr),
    .pc_reg_addr(pc_reg_addr), .pc_reg_wdata(pc_reg_wdata), .pc_reg_rdata(pc_reg_rdata),
    .smp_valid(smp_valid), .smp_data(smp_data), .smp_ready(smp_ready), .busy(busy),
    .sample_cnt(sample_cnt), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  // Counter block: CTRL at 0x00 (reset 0x01, EN=1); count words tagged with the freeze count.
  logic [31:0] ctrl_reg;
  logic [7:0]  frz_cnt = 8'd0;
  function automatic logic [31:0] cnt_word(input logic [7:0] a, input logic [7:0] f);
    return {16'hC0DE, f, a};
  endfunction
  assign pc_reg_rdata = (pc_reg_addr == 8'h00) ? ctrl_reg : cnt_word(pc_reg_addr, frz_cnt);
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) ctrl_reg <= 32'h1;
    else if (pc_reg_wr && pc_reg_addr == 8'h00) ctrl_reg <= pc_reg_wdata;
  end
  always @(posedge clk) begin
    if (rst_n && pc_reg_wr && pc_reg_addr == 8'h00 && pc_reg_wdata[2]) frz_cnt <= frz_cnt + 8'd1;
  end

  logic [31:0] wr_log[$];
  logic [31:0] pop_log[$];
  always @(posedge clk) begin
    if (rst_n && pc_reg_wr) wr_log.push_back(pc_reg_wdata);
    if (rst_n && smp_valid && smp_ready) pop_log.push_back(smp_data);
  end

  int n_tot = 0, n_bad = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] seq_addr(input int k);
    if (k == 0) return 8'h10;
    if (k == 1) return 8'h14;
    return 8'(32'h20 + 4 * (k - 2));
  endfunction

  // Reference model: sequence position (-1 idle, 0 CTRL read, 1 freeze, 2..W+1 reads,
  // W+2 restore) plus a queue holding the expected FIFO contents.
  int          m_pos = -1;
  logic [31:0] m_tmr = 0;
  logic        m_pend = 0, m_en_prev = 0;
  logic [7:0]  m_saved = 0;
  logic [15:0] m_scnt = 0, m_dcnt = 0;
  logic [31:0] m_q[$];
  logic        e_trig, e_want, e_start, e_rej, e_act, e_wr, e_valid;
  int          e_pos, e_drop;
  logic [7:0]  e_addr;
  logic [31:0] e_wdata;

  always @(negedge clk) begin
    if (!rst_n) begin
      m_pos = -1; m_tmr = 0; m_pend = 0; m_en_prev = 0; m_saved = 0; m_scnt = 0; m_dcnt = 0;
      m_q.delete();
    end else begin
      e_trig  = sample_now || (enable && period != 0 && m_tmr == period - 1);
      e_want  = (m_pos < 0) && (m_pend || e_trig);
      e_start = e_want && (int'(DEPTH) - m_q.size() >= SW);
      e_rej   = e_want && !e_start;
      e_act   = e_start || (m_pos >= 0);
      e_pos   = e_start ? 0 : m_pos;
      e_wr = 1'b0; e_addr = 8'h00; e_wdata = 32'h0;
      if (!e_act) begin
        e_wr = host_req && host_wr; e_addr = host_addr; e_wdata = host_wdata;
      end else if (e_pos == 1) begin
        e_wr = 1'b1; e_wdata = {24'h0, m_saved | 8'h04};
      end else if (e_pos == W + 2) begin
        e_wr = 1'b1; e_wdata = {24'h0, m_saved};
      end else if (e_pos >= 2) begin
        e_addr = seq_addr(e_pos - 2);
      end
      e_valid = (m_q.size() != 0);
      chk("busy", 32'(busy), 32'(e_act));
      chk("host_ready", 32'(host_ready), 32'(host_req && !e_act));
      chk("pc_reg_wr", 32'(pc_reg_wr), 32'(e_wr));
      chk("pc_reg_addr", 32'(pc_reg_addr), 32'(e_addr));
      if (e_wr) chk("pc_reg_wdata", pc_reg_wdata, e_wdata);
      if (!e_act) chk("host_rdata", host_rdata,
                      (host_addr == 8'h00) ? ctrl_reg : cnt_word(host_addr, frz_cnt));
      chk("smp_valid", 32'(smp_valid), 32'(e_valid));
      chk("smp_data", smp_data, e_valid ? m_q[0] : 32'h0);
      chk("sample_cnt", 32'(sample_cnt), 32'(m_scnt));
      chk("drop_cnt", 32'(drop_cnt), 32'(m_dcnt));
      if (e_valid && smp_ready) void'(m_q.pop_front());
      if (e_act && e_pos == 0) m_saved = ctrl_reg[7:0] & 8'hFD;
      if (e_act && HDR == 1 && e_pos == 1) m_q.push_back({m_scnt, 8'(W), 8'hA5});
      if (e_act && e_pos >= 2 && e_pos <= W + 1)
        m_q.push_back(cnt_word(seq_addr(e_pos - 2), frz_cnt));
      if (e_act && e_pos == W + 2) m_scnt++;
      m_pos  = (!e_act || e_pos == W + 2) ? -1 : e_pos + 1;
      e_drop = int'(e_trig && m_pend) + int'(e_rej);
      if (enable && !m_en_prev) m_dcnt = 0;
      else m_dcnt = (32'(m_dcnt) + e_drop > 32'hFFFF) ? 16'hFFFF : m_dcnt + 16'(e_drop);
      if (e_want) m_pend = 1'b0;
      else if (e_trig) m_pend = 1'b1;
      if (!enable) m_tmr = 0;
      else if (period != 0) m_tmr = (m_tmr == period - 1) ? 0 : m_tmr + 1;
      m_en_prev = enable;
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse();
    sample_now = 1'b1;
    step(1);
    sample_now = 1'b0;
  endtask

  int lo, got_rd, bcnt, first_idle, nwr;

  initial begin
    #1 rst_n = 1'b0;
    #11;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_smp_valid", 32'(smp_valid), 0);
    chk("rst_smp_data", smp_data, 0);
    chk("rst_sample_cnt", 32'(sample_cnt), 0);
    chk("rst_drop_cnt", 32'(drop_cnt), 0);
    chk("rst_host_ready", 32'(host_ready), 0);
    chk("rst_pc_reg_wr", 32'(pc_reg_wr), 0);
    step(1);
    rst_n = 1'b1;

    // Periodic sampling with draining consumer.
    smp_ready = 1'b1; period = 32'd100; enable = 1'b1;
    step(230);
    chk("t1_sample_cnt", 32'(sample_cnt), 2);
    chk("t1_pop_count", pop_log.size(), 2 * SW);
    chk("t1_freeze_wr", wr_log[0], 32'h5);
    chk("t1_restore_wr", wr_log[1], 32'h1);
    chk("t1_first_data", pop_log[HDR], 32'hC0DE0110);
    chk("t1_second_data", pop_log[HDR + 1], 32'hC0DE0114);
    chk("t1_last_data", pop_log[HDR + W - 1], 32'hC0DE015C);
`ifdef PERF_SAMPLE_TAG_EN
    chk("t1_hdr0", pop_log[0], 32'h000012A5);
    chk("t1_hdr1", pop_log[SW], 32'h000112A5);
`endif
    enable = 1'b0;
    step(5);

    // Host held off by a manual sample.
    host_req = 1'b1; host_wr = 1'b0; host_addr = 8'h10; sample_now = 1'b1;
    lo = 0; got_rd = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!host_ready) lo++;
      else if (lo > 0 && got_rd == 0) begin
        got_rd = 1;
        chk("t2_host_rdata", host_rdata, 32'hC0DE0310);
      end
      step(1);
      sample_now = 1'b0;
    end
    chk("t2_blocked_cycles", lo, 21);
    chk("t2_host_resumed", got_rd, 1);
    host_req = 1'b0;

    // FIFO too full for a second sample.
    smp_ready = 1'b0;
    nwr = wr_log.size();
    pulse();
    step(29);
    sample_now = 1'b1;
    @(negedge clk);
    chk("t3_drop_no_wr", 32'(pc_reg_wr), 0);
    chk("t3_drop_not_busy", 32'(busy), 0);
    step(1);
    sample_now = 1'b0;
    bcnt = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (busy) bcnt++;
    end
    chk("t3_idle_after_drop", bcnt, 0);
    chk("t3_wr_count", wr_log.size() - nwr, 2);
    chk("t3_drop_cnt", 32'(drop_cnt), 1);
    chk("t3_sample_cnt", 32'(sample_cnt), 4);
    smp_ready = 1'b1;
    step(30);

    // Two extra triggers during a sample: one pends, one drops.
    pulse();
    step(4);
    pulse();
    step(2);
    pulse();
    bcnt = 0; first_idle = -1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (busy) bcnt++;
      else if (first_idle < 0) first_idle = i;
    end
    step(1);
    chk("t4_busy_cycles", bcnt, 33);
    chk("t4_busy_run", first_idle, 33);
    chk("t4_drop_cnt", 32'(drop_cnt), 2);
    chk("t4_sample_cnt", 32'(sample_cnt), 6);
    period = 32'd0; enable = 1'b1;
    step(1);
    chk("t4_drop_clear", 32'(drop_cnt), 0);
    enable = 1'b0;
    step(2);

    // Asynchronous reset during READ word 5.
    smp_ready = 1'b0;
    pulse();
    step(6);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_busy", 32'(busy), 0);
    chk("t5_smp_valid", 32'(smp_valid), 0);
    chk("t5_sample_cnt", 32'(sample_cnt), 0);
    chk("t5_host_ready", 32'(host_ready), 0);
    step(2);
    rst_n = 1'b1;
    nwr = wr_log.size();
    pulse();
    step(30);
    chk("t5_resample_cnt", 32'(sample_cnt), 1);
    chk("t5_wr_count", wr_log.size() - nwr, 2);
    chk("t5_freeze_wr", wr_log[nwr], 32'h5);
    chk("t5_restore_wr", wr_log[nwr + 1], 32'h1);
    chk("t5_fifo_valid", 32'(smp_valid), 1);

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end
endmodule
